// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (start, 8 data LSB first, even parity, stop) with a show-ahead FIFO.
// Ports: clk, reset (async active-low), baud_select (16x divisor select), Rx_EN (receiver enable),
//        RxD (async serial line), Rx_RD (pop head) -> Rx_DATA/Rx_PERROR/Rx_FERROR (FIFO head),
//        Rx_VALID (FIFO not empty), Rx_OVERRUN (sticky drop flag), Rx_BUSY (frame in progress).
module uart_rx_fifo #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  input  logic       Rx_RD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR,
  output logic       Rx_VALID,
  output logic       Rx_OVERRUN,
  output logic       Rx_BUSY
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES:0] sync_q;
  logic [2:0] baud_q;
  logic [13:0] div, tcnt_q, tcnt_d;
  logic [3:0] s_q, s_d;
  logic [2:0] idx_q, idx_d;
  logic [1:0] samp_q, samp_d;
  logic [7:0] sh_q, sh_d;
  logic perr_q, perr_d, ferr_q, ferr_d, push_q, push_d, ovr_q, ovr_d;
  logic [9:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] cnt_q, cnt_d;
  logic rxd, fall, tick, maj, mid, last, pop, full, wr;
  logic [9:0] head;
  assign div = baud_select == 3'd0 ? 14'd10417 :
               baud_select == 3'd1 ? 14'd2604  :
               baud_select == 3'd2 ? 14'd651   :
               baud_select == 3'd3 ? 14'd326   :
               baud_select == 3'd4 ? 14'd163   :
               baud_select == 3'd5 ? 14'd81    :
               baud_select == 3'd6 ? 14'd54    : 14'd27;
  // The extra flop past the synchroniser holds the previous synchronised level for edge detection.
  assign rxd  = sync_q[SYNC_STAGES-1];
  assign fall = sync_q[SYNC_STAGES] & ~rxd;
  // A baud change suppresses the tick that cycle while the counter restarts.
  assign tick = baud_select == baud_q && tcnt_q == div - 14'd1;
  // samp_q holds the samples taken at s=6 and s=7; the s=8 sample is the live line.
  assign maj  = (samp_q[1] & samp_q[0]) | (rxd & (samp_q[1] | samp_q[0]));
  assign mid  = tick && s_q == 4'd8;
  assign last = tick && s_q == 4'd15;
  always_comb begin
    state_d = state_q;
    tcnt_d  = (baud_select != baud_q || tick) ? 14'd0 : tcnt_q + 14'd1;
    s_d     = tick ? s_q + 4'd1 : s_q;
    samp_d  = tick ? {samp_q[0], rxd} : samp_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push_d  = 1'b0;
    if (!Rx_EN) state_d = IDLE;
    else case (state_q)
      IDLE: if (fall) begin
        state_d = START;
        tcnt_d  = 14'd0;
        s_d     = 4'd0;
      end
      START: if (mid && maj) state_d = IDLE;
        else if (last) begin
          state_d = DATA;
          idx_d   = 3'd0;
        end
      DATA: begin
        if (mid) sh_d[idx_q] = maj;
        if (last) begin
          state_d = idx_q == 3'd7 ? PARITY : DATA;
          idx_d   = idx_q + 3'd1;
        end
      end
      PARITY: begin
        if (mid) perr_d = (^sh_q) ^ maj;
        if (last) state_d = STOP;
      end
      STOP: if (mid) begin
        ferr_d  = ~maj;
        push_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign Rx_VALID = cnt_q != '0;
  assign pop      = Rx_RD && Rx_VALID;
  assign full     = cnt_q == (AW+1)'(FIFO_DEPTH);
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign wr       = push_q && (!full || pop);
  assign cnt_d    = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
  assign ovr_d    = Rx_EN && (ovr_q || (push_q && full && !pop));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sync_q  <= '1;
      baud_q  <= 3'd0;
      tcnt_q  <= 14'd0;
      s_q     <= 4'd0;
      idx_q   <= 3'd0;
      samp_q  <= 2'b11;
      sh_q    <= 8'd0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      push_q  <= 1'b0;
      ovr_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-1:0], RxD};
      baud_q  <= baud_select;
      tcnt_q  <= tcnt_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      samp_q  <= samp_d;
      sh_q    <= sh_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      push_q  <= push_d;
      ovr_q   <= ovr_d;
      wptr_q  <= wr ? wptr_q + AW'(1) : wptr_q;
      rptr_q  <= pop ? rptr_q + AW'(1) : rptr_q;
      cnt_q   <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= {perr_q, ferr_q, sh_q};
  end
  assign head       = mem_q[rptr_q];
  assign Rx_DATA    = Rx_VALID ? head[7:0] : 8'd0;
  assign Rx_FERROR  = Rx_VALID && head[8];
  assign Rx_PERROR  = Rx_VALID && head[9];
  assign Rx_OVERRUN = ovr_q;
  assign Rx_BUSY    = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo driving serial frames and checking the FIFO head.
module tb_uart_rx_fifo;
  logic clk = 1'b0, reset = 1'b0;
  logic [2:0] baud_select = 3'b111;
  logic Rx_EN = 1'b1, RxD = 1'b1, Rx_RD = 1'b0;
  logic [7:0] Rx_DATA;
  logic Rx_PERROR, Rx_FERROR, Rx_VALID, Rx_OVERRUN, Rx_BUSY;
  logic popped;
  logic [7:0] exp4 [4];
  int total = 0, bad = 0;

  uart_rx_fifo dut (
    .clk(clk), .reset(reset), .baud_select(baud_select), .Rx_EN(Rx_EN), .RxD(RxD),
    .Rx_RD(Rx_RD), .Rx_DATA(Rx_DATA), .Rx_PERROR(Rx_PERROR), .Rx_FERROR(Rx_FERROR),
    .Rx_VALID(Rx_VALID), .Rx_OVERRUN(Rx_OVERRUN), .Rx_BUSY(Rx_BUSY)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {VALID, PERROR, FERROR, DATA}
  task automatic chk_head(input string tag, input logic [7:0] d, input logic p, input logic f);
    chk(tag, {Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA}, {1'b1, p, f, d});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic flip, input logic stop);
    return {stop, (^d) ^ flip, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n, input int div);
    for (int b = 0; b < n; b++) begin
      RxD = f[b];
      repeat (16 * div) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop, input int div);
    send_bits(frame(d, flip, stop), 11, div);
    RxD = 1'b1;
  endtask

  task automatic pop();
    Rx_RD = 1'b1;
    @(negedge clk);
    Rx_RD = 1'b0;
  endtask

  initial begin
    exp4 = '{8'h02, 8'h03, 8'h04, 8'h06};
    idle(3);
    chk("rst_outputs", {Rx_DATA, Rx_PERROR, Rx_FERROR, Rx_VALID, Rx_OVERRUN, Rx_BUSY}, 0);
    reset = 1'b1;
    idle(5);
    chk("idle_busy", Rx_BUSY, 0);
    // clean frame at the fastest rate, checked right at the end of the 11-bit frame
    send_frame(8'hDD, 1'b0, 1'b1, 27);
    chk_head("t1_dd", 8'hDD, 1'b0, 1'b0);
    pop();
    chk("t1_valid_after_rd", Rx_VALID, 0);
    // wrong parity bit
    send_frame(8'hA5, 1'b1, 1'b1, 27);
    chk_head("t2_a5_perr", 8'hA5, 1'b1, 1'b0);
    pop();
    // framing error then a clean frame at a slower rate
    baud_select = 3'b110;
    idle(4);
    send_frame(8'h3C, 1'b0, 1'b0, 54);
    chk_head("t3_3c_ferr", 8'h3C, 1'b0, 1'b1);
    pop();
    idle(10);
    send_frame(8'h81, 1'b0, 1'b1, 54);
    chk_head("t3_81", 8'h81, 1'b0, 1'b0);
    pop();
    chk("t3_empty", Rx_VALID, 0);
    // overrun: five frames into a four-entry FIFO
    baud_select = 3'b111;
    idle(4);
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1, 27);
    chk_head("t4_head01", 8'h01, 1'b0, 1'b0);
    chk("t4_overrun", Rx_OVERRUN, 1);
    // sixth frame lands while the full FIFO is popped in the same cycle
    send_bits(frame(8'h06, 1'b0, 1'b1), 10, 27);
    RxD = 1'b1;
    popped = 1'b0;
    for (int k = 0; k < 432; k++) begin
      @(negedge clk);
      Rx_RD = 1'b0;
      if (!popped && !Rx_BUSY) begin
        Rx_RD = 1'b1;
        popped = 1'b1;
      end
    end
    Rx_RD = 1'b0;
    chk("t4_stop_seen", popped, 1);
    for (int i = 0; i < 4; i++) begin
      chk_head($sformatf("t4_read%0d", i), exp4[i], 1'b0, 1'b0);
      pop();
    end
    chk("t4_empty", Rx_VALID, 0);
    chk("t4_overrun_sticky", Rx_OVERRUN, 1);
    // 5-tick glitch is rejected
    RxD = 1'b0;
    idle(100);
    chk("t5_busy_in_glitch", Rx_BUSY, 1);
    idle(35);
    RxD = 1'b1;
    idle(864);
    chk("t5_busy_after", Rx_BUSY, 0);
    chk("t5_no_entry", Rx_VALID, 0);
    // reset during data bit 4
    send_bits(frame(8'hFF, 1'b0, 1'b1), 5, 27);
    idle(200);
    chk("t6_busy_mid", Rx_BUSY, 1);
    reset = 1'b0;
    RxD = 1'b1;
    idle(3);
    chk("t6_rst_state", {Rx_BUSY, Rx_VALID, Rx_OVERRUN}, 0);
    reset = 1'b1;
    idle(20);
    send_frame(8'h55, 1'b0, 1'b1, 27);
    chk_head("t6_55", 8'h55, 1'b0, 1'b0);
    // receiver disabled mid-frame
    send_bits(frame(8'h77, 1'b0, 1'b1), 4, 27);
    chk("t6_busy_en", Rx_BUSY, 1);
    Rx_EN = 1'b0;
    RxD = 1'b1;
    @(negedge clk);
    chk("t6_busy_dis", Rx_BUSY, 0);
    idle(864);
    Rx_EN = 1'b1;
    idle(10);
    chk_head("t6_preserved", 8'h55, 1'b0, 1'b0);
    pop();
    chk("t6_only_one", Rx_VALID, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
